// File: rtl/uart_cmd_rx.sv
// UART 8N1 command receiver: deserialises frames, whitelists 'T'/'D' and holds the accepted byte until cmd_ready.
// Optional build macro UART_CMD_LOWERCASE_EN also accepts 't'/'d', folding them to uppercase before storage.
`timescale 1ns/1ps
module uart_cmd_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       cmd_ready,
    output logic [7:0] rx_byte,
    output logic       valid_command,
    output logic       cmd_reject,
    output logic       frame_error,
    output logic       overrun
);

    localparam int TICK_DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TCNT_W       = $clog2(OVERSAMPLE) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] HALF_LAST = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] BIT_LAST  = TCNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic is_whitelisted(input logic [7:0] b);
        logic hit;
        hit = (b == 8'h54) || (b == 8'h44);
`ifdef UART_CMD_LOWERCASE_EN
        hit = hit || (b == 8'h74) || (b == 8'h64);
`endif
        return hit;
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef UART_CMD_LOWERCASE_EN
        if (b == 8'h74) begin
            r = 8'h54;
        end else if (b == 8'h64) begin
            r = 8'h44;
        end else begin
            r = b;
        end
`endif
        return r;
    endfunction

    logic [1:0]        sync_r;
    logic [1:0]        fill_r;
    logic              rx_s;
    logic              rx_prev_r;
    logic              start_edge_s;
    logic [DIV_W-1:0]  div_cnt_r;
    logic              tick_s;

    state_t            state_r, state_n;
    logic [TCNT_W-1:0] tick_cnt_r, tick_cnt_n;
    logic [2:0]        bit_idx_r, bit_idx_n;
    logic [7:0]        shift_r, shift_n;
    logic              stop_r, stop_n;

    logic [7:0]        rx_byte_r;
    logic              valid_r;
    logic              reject_r;
    logic              ferr_r;
    logic              ovr_r;

    logic              eval_s;
    logic              handshake_s;
    logic              still_pending_s;
    logic              accept_s;

    assign rx_s = sync_r[1];
    // The sync flops reset high, so fill_r keeps that fake idle level from ever arming the edge detector.
    assign start_edge_s = rx_prev_r && !rx_s && (state_r == IDLE);
    assign tick_s       = (div_cnt_r == DIV_LAST);

    // Two-flop synchroniser plus fill tracking and previous-level register for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r    <= 2'b11;
            fill_r    <= 2'b00;
            rx_prev_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], rx_serial};
            fill_r    <= {fill_r[0], 1'b1};
            rx_prev_r <= rx_s & fill_r[1];
        end
    end

    // Free-running oversample tick divider, realigned on each start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= '0;
        end else if (start_edge_s || tick_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Receive FSM and datapath state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            stop_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            tick_cnt_r <= tick_cnt_n;
            bit_idx_r  <= bit_idx_n;
            shift_r    <= shift_n;
            stop_r     <= stop_n;
        end
    end

    // Next-state logic: mid-bit sampling of start, data (LSB first) and stop bits.
    always_comb begin
        state_n    = state_r;
        tick_cnt_n = tick_cnt_r;
        bit_idx_n  = bit_idx_r;
        shift_n    = shift_r;
        stop_n     = stop_r;
        case (state_r)
            IDLE: begin
                if (start_edge_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (!tick_s) begin
                    state_n = START;
                end else if (tick_cnt_r != HALF_LAST) begin
                    tick_cnt_n = tick_cnt_r + TCNT_W'(1);
                end else if (!rx_s) begin
                    state_n    = DATA;
                    tick_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!tick_s) begin
                    state_n = DATA;
                end else if (tick_cnt_r != BIT_LAST) begin
                    tick_cnt_n = tick_cnt_r + TCNT_W'(1);
                end else begin
                    tick_cnt_n = '0;
                    shift_n    = {rx_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx_r + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick_s) begin
                    state_n = STOP;
                end else if (tick_cnt_r != BIT_LAST) begin
                    tick_cnt_n = tick_cnt_r + TCNT_W'(1);
                end else begin
                    stop_n  = rx_s;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Frame evaluation terms; a same-cycle handshake frees the holding slot first.
    always_comb begin
        eval_s          = (state_r == DONE);
        handshake_s     = valid_r && cmd_ready;
        still_pending_s = valid_r && !cmd_ready;
        accept_s        = eval_s && stop_r && is_whitelisted(shift_r);
    end

    // Registered command holding slot and single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte_r <= 8'h00;
            valid_r   <= 1'b0;
            reject_r  <= 1'b0;
            ferr_r    <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            ferr_r   <= eval_s && !stop_r;
            reject_r <= eval_s && stop_r && !is_whitelisted(shift_r);
            ovr_r    <= accept_s && still_pending_s;
            if (accept_s && !still_pending_s) begin
                rx_byte_r <= fold_case(shift_r);
                valid_r   <= 1'b1;
            end else if (handshake_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign rx_byte       = rx_byte_r;
    assign valid_command = valid_r;
    assign cmd_reject    = reject_r;
    assign frame_error   = ferr_r;
    assign overrun       = ovr_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed self-checking bench for uart_cmd_rx at TICK_DIV=1 (one bit = 16 clk).
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b1;
    logic       cmd_ready = 1'b0;
    logic [7:0] rx_byte;
    logic       valid_command;
    logic       cmd_reject;
    logic       frame_error;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int valid_cycles, rej_cnt, ferr_cnt, ovr_cnt;
    logic [7:0] last_byte;

    uart_cmd_rx #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_serial     (rx_serial),
        .cmd_ready     (cmd_ready),
        .rx_byte       (rx_byte),
        .valid_command (valid_command),
        .cmd_reject    (cmd_reject),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        valid_cycles = 0;
        rej_cnt      = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        last_byte    = 8'hxx;
    endtask

    task automatic run_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_command) begin
                valid_cycles++;
                last_byte = rx_byte;
            end
            if (cmd_reject)  rej_cnt++;
            if (frame_error) ferr_cnt++;
            if (overrun)     ovr_cnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        run_clk(16);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            run_clk(16);
        end
        rx_serial = stop_bit;
        run_clk(16);
        rx_serial = 1'b1;
        run_clk(20);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        run_clk(3);
        checks++;
        if (rx_byte !== 8'h00 || valid_command !== 1'b0 || cmd_reject !== 1'b0 ||
            frame_error !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs actual byte=%h v=%b rej=%b fe=%b ov=%b required 00/0/0/0/0",
                     rx_byte, valid_command, cmd_reject, frame_error, overrun);
        end
        rst = 1'b1;
        clear_counts();
        run_clk(20);
        checks++;
        if (valid_cycles + rej_cnt + ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL reset_idle_quiet actual events=%0d required 0",
                     valid_cycles + rej_cnt + ferr_cnt + ovr_cnt);
        end
    endtask

    task automatic test_accept();
        cmd_ready = 1'b1;
        clear_counts();
        send_frame(8'h54, 1'b1);
        checks++;
        if (valid_cycles !== 1) begin
            failures++;
            $display("FAIL t1_valid_cycles actual=%0d required 1", valid_cycles);
        end
        checks++;
        if (last_byte !== 8'h54) begin
            failures++;
            $display("FAIL t1_rx_byte actual=%h required 54", last_byte);
        end
        checks++;
        if (rej_cnt + ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t1_flags actual=%0d required 0", rej_cnt + ferr_cnt + ovr_cnt);
        end
    endtask

    task automatic test_hold();
        cmd_ready = 1'b0;
        clear_counts();
        send_frame(8'h44, 1'b1);
        run_clk(100);
        checks++;
        if (valid_command !== 1'b1 || rx_byte !== 8'h44) begin
            failures++;
            $display("FAIL t2_held actual v=%b byte=%h required 1/44", valid_command, rx_byte);
        end
        checks++;
        if (valid_cycles < 100 || last_byte !== 8'h44) begin
            failures++;
            $display("FAIL t2_stable actual cycles=%0d byte=%h required >=100/44", valid_cycles, last_byte);
        end
        cmd_ready = 1'b1;
        clear_counts();
        run_clk(1);
        checks++;
        if (valid_command !== 1'b0 || rx_byte !== 8'h44) begin
            failures++;
            $display("FAIL t2_release actual v=%b byte=%h required 0/44", valid_command, rx_byte);
        end
    endtask

    task automatic test_reject();
        cmd_ready = 1'b1;
        clear_counts();
        send_frame(8'h41, 1'b1);
        checks++;
        if (rej_cnt !== 1 || valid_cycles !== 0 || ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t3_reject_41 actual rej=%0d v=%0d other=%0d required 1/0/0",
                     rej_cnt, valid_cycles, ferr_cnt + ovr_cnt);
        end
        clear_counts();
        send_frame(8'h74, 1'b1);
`ifdef UART_CMD_LOWERCASE_EN
        checks++;
        if (valid_cycles !== 1 || last_byte !== 8'h54 || rej_cnt !== 0) begin
            failures++;
            $display("FAIL t3_fold_74 actual v=%0d byte=%h rej=%0d required 1/54/0",
                     valid_cycles, last_byte, rej_cnt);
        end
`else
        checks++;
        if (rej_cnt !== 1 || valid_cycles !== 0) begin
            failures++;
            $display("FAIL t3_reject_74 actual rej=%0d v=%0d required 1/0", rej_cnt, valid_cycles);
        end
`endif
    endtask

    task automatic test_frame_error();
        cmd_ready = 1'b1;
        clear_counts();
        send_frame(8'h54, 1'b0);
        checks++;
        if (ferr_cnt !== 1 || valid_cycles !== 0 || rej_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t4_frame_error actual fe=%0d v=%0d other=%0d required 1/0/0",
                     ferr_cnt, valid_cycles, rej_cnt + ovr_cnt);
        end
        clear_counts();
        rx_serial = 1'b0;
        run_clk(4);
        rx_serial = 1'b1;
        run_clk(200);
        checks++;
        if (valid_cycles + rej_cnt + ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t4_glitch actual events=%0d required 0",
                     valid_cycles + rej_cnt + ferr_cnt + ovr_cnt);
        end
        clear_counts();
        send_frame(8'h54, 1'b1);
        checks++;
        if (valid_cycles !== 1 || last_byte !== 8'h54) begin
            failures++;
            $display("FAIL t4_after_glitch actual v=%0d byte=%h required 1/54", valid_cycles, last_byte);
        end
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        clear_counts();
        send_frame(8'h54, 1'b1);
        send_frame(8'h44, 1'b1);
        checks++;
        if (ovr_cnt !== 1 || rej_cnt + ferr_cnt !== 0) begin
            failures++;
            $display("FAIL t5_overrun actual ov=%0d other=%0d required 1/0", ovr_cnt, rej_cnt + ferr_cnt);
        end
        checks++;
        if (valid_command !== 1'b1 || rx_byte !== 8'h54) begin
            failures++;
            $display("FAIL t5_kept actual v=%b byte=%h required 1/54", valid_command, rx_byte);
        end
        cmd_ready = 1'b1;
        clear_counts();
        run_clk(40);
        checks++;
        if (valid_cycles !== 0 || valid_command !== 1'b0 || rx_byte !== 8'h54) begin
            failures++;
            $display("FAIL t5_single_transfer actual cycles=%0d v=%b byte=%h required 0/0/54",
                     valid_cycles, valid_command, rx_byte);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'h44;
        cmd_ready = 1'b0;
        send_frame(8'h54, 1'b1);
        rx_serial = 1'b0;
        run_clk(16);
        for (int i = 0; i < 3; i++) begin
            rx_serial = d[i];
            run_clk(16);
        end
        rx_serial = d[3];
        run_clk(8);
        checks++;
        if (valid_command !== 1'b1) begin
            failures++;
            $display("FAIL t6_pre_pending actual v=%b required 1", valid_command);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rx_byte !== 8'h00 || valid_command !== 1'b0 || cmd_reject !== 1'b0 ||
            frame_error !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL t6_async_reset actual byte=%h v=%b rej=%b fe=%b ov=%b required 00/0/0/0/0",
                     rx_byte, valid_command, cmd_reject, frame_error, overrun);
        end
        rx_serial = 1'b0;
        run_clk(5);
        rst = 1'b1;
        clear_counts();
        run_clk(200);
        checks++;
        if (valid_cycles + rej_cnt + ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t6_low_line_no_start actual events=%0d required 0",
                     valid_cycles + rej_cnt + ferr_cnt + ovr_cnt);
        end
        rx_serial = 1'b1;
        run_clk(20);
        cmd_ready = 1'b1;
        clear_counts();
        send_frame(8'h44, 1'b1);
        checks++;
        if (valid_cycles !== 1 || last_byte !== 8'h44 || rej_cnt + ferr_cnt + ovr_cnt !== 0) begin
            failures++;
            $display("FAIL t6_after_reset actual v=%0d byte=%h flags=%0d required 1/44/0",
                     valid_cycles, last_byte, rej_cnt + ferr_cnt + ovr_cnt);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_accept();
        test_hold();
        test_reject();
        test_frame_error();
        test_overrun();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
